// File: rtl/cnff_run_encoder.sv
// Run-length encoder for the cnff result stream: each maximal run of equal
// bits becomes a {bit, length} record, buffered in a small FWFT FIFO.
module cnff_run_encoder #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_bit,
  input  logic                     in_en,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic                     out_bit,
  output logic [LEN_W-1:0]         out_len,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic             b;
    logic [LEN_W-1:0] len;
  } rec_t;

  state_t           state;
  logic             cur_bit;
  logic [LEN_W-1:0] cur_len;

  logic             push_req;
  rec_t             push_rec;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  rec_t             mem [DEPTH];

  logic             full;
  logic             pop;
  logic             wr_en;

  // A run closes on flush, on a bit change, or when the length saturates.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    push_req = 1'b0;
    push_rec = '{b: cur_bit, len: cur_len};
    if (state == RUN) begin
      if (flush)
        push_req = 1'b1;
      else if (in_en && ((in_bit != cur_bit) || (cur_len == MAX)))
        push_req = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_bit <= 1'b0;
      cur_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_en) begin
            cur_bit <= in_bit;
            cur_len <= LEN_W'(1);
            state   <= RUN;
          end
        end
        RUN: begin
          if (in_en) begin
            if (!flush && (in_bit == cur_bit) && (cur_len != MAX)) begin
              cur_len <= cur_len + LEN_W'(1);
            end else begin
              cur_bit <= in_bit;
              cur_len <= LEN_W'(1);
            end
          end else if (flush) begin
            cur_len <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = (count != '0) && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count and unused entries are never shown.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= push_rec;
  end

  assign out_valid = (count != '0);
  assign out_bit   = out_valid & mem[rd_ptr].b;
  assign out_len   = out_valid ? mem[rd_ptr].len : '0;
  assign level     = count;

endmodule

// File: tb/tb_cnff_run_encoder.sv
// Scoreboard bench for cnff_run_encoder: expected records are queued as
// stimulus is driven and compared whenever the DUT hands a record out.
module tb_cnff_run_encoder;

  localparam int LEN_W = 3;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_bit = 1'b0;
  logic                   in_en = 1'b0;
  logic                   flush = 1'b0;
  logic                   out_ready = 1'b0;
  logic                   out_valid;
  logic                   out_bit;
  logic [LEN_W-1:0]       out_len;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;

  int total = 0;
  int bad = 0;
  logic [LEN_W:0] exp_q [$];

  bit pat4 [11] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0};
  bit pat6 [12] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  always #5 clk = ~clk;

  cnff_run_encoder #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_en     (in_en),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_len   (out_len),
    .level     (level),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LEN_W:0] rec(input logic b, input int len);
    return {b, LEN_W'(len)};
  endfunction

  // Outputs are stable at the falling edge; a handshake seen here pops on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0)
        check("unexpected_rec", 32'({out_bit, out_len}), 32'hffff);
      else
        check("rec", 32'({out_bit, out_len}), 32'(exp_q.pop_front()));
    end
  end

  task automatic drive(input logic en, input logic b, input logic fl);
    in_en  = en;
    in_bit = b;
    flush  = fl;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(posedge clk);
    #1;
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_level0"}, 32'(level), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int pushes;

    #2;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream with two records queued, then a fresh single-bit run.
    out_ready = 1'b0;
    drive(1, 0, 0);
    drive(1, 1, 0);
    drive(1, 0, 0);
    check("t1_level2", 32'(level), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_rst_valid", 32'(out_valid), 0);
    check("t1_rst_bit", 32'(out_bit), 0);
    check("t1_rst_len", 32'(out_len), 0);
    check("t1_rst_level", 32'(level), 0);
    check("t1_rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(rec(1, 1));
    drive(1, 1, 0);
    check("t1_no_early", 32'(out_valid), 0);
    drive(0, 0, 1);
    drain("t1");

    // Basic encode with first-record latency.
    exp_q.push_back(rec(0, 3));
    exp_q.push_back(rec(1, 2));
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("t2_no_early", 32'(out_valid), 0);
    drive(1, 1, 0);
    check("t2_lat_valid", 32'(out_valid), 1);
    check("t2_lat_head", 32'({out_bit, out_len}), 32'(rec(0, 3)));
    drive(1, 1, 0);
    drive(0, 0, 1);
    drain("t2");

    // Saturation: ten ones split into MAX plus remainder.
    exp_q.push_back(rec(1, 7));
    exp_q.push_back(rec(1, 3));
    repeat (10) drive(1, 1, 0);
    drive(0, 0, 1);
    drain("t3");

    // Backpressure: six pushes into a four-deep FIFO, last two dropped.
    out_ready = 1'b0;
    exp_q.push_back(rec(0, 1));
    exp_q.push_back(rec(1, 2));
    exp_q.push_back(rec(0, 3));
    exp_q.push_back(rec(1, 1));
    pushes = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1, pat4[i], 0);
      if (i > 0 && pat4[i] != pat4[i-1])
        pushes++;
      check($sformatf("t4_level_%0d", i), 32'(level), (pushes > DEPTH) ? DEPTH : pushes);
      check($sformatf("t4_ovf_%0d", i), 32'(overflow), (pushes > DEPTH) ? 1 : 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t4_drain_level_%0d", k), 32'(level), DEPTH - 1 - k);
    end
    check("t4_drained_valid", 32'(out_valid), 0);
    check("t4_ovf_sticky", 32'(overflow), 1);
    exp_q.push_back(rec(0, 1));
    drive(0, 0, 1);
    drain("t4");

    // Flush together with a sample starts a new run.
    exp_q.push_back(rec(0, 2));
    exp_q.push_back(rec(1, 1));
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 1, 1);
    check("t5_level", 32'(level), 1);
    check("t5_head", 32'({out_bit, out_len}), 32'(rec(0, 2)));
    drive(0, 0, 1);
    drain("t5");

    // Full FIFO with simultaneous pop and push.
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(rec(0, 1));
    exp_q.push_back(rec(1, 2));
    exp_q.push_back(rec(0, 3));
    exp_q.push_back(rec(1, 4));
    for (int i = 0; i < 12; i++)
      drive(1, pat6[i], 0);
    check("t6_full_level", 32'(level), DEPTH);
    check("t6_full_ovf", 32'(overflow), 0);
    exp_q.push_back(rec(0, 2));
    out_ready = 1'b1;
    drive(1, 1, 0);
    check("t6_pp_level", 32'(level), DEPTH);
    check("t6_pp_ovf", 32'(overflow), 0);
    check("t6_pp_head", 32'({out_bit, out_len}), 32'(rec(1, 2)));
    exp_q.push_back(rec(1, 1));
    drive(0, 0, 1);
    check("t6_pp2_level", 32'(level), DEPTH);
    drain("t6");
    check("t6_final_ovf", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
